tcm_mem: RTL and testbench

Dual-channel tightly-coupled memory for the core. A single-ported, byte-addressed word array is shared by an instruction-fetch channel and a load/store channel. Each channel uses a req/gnt request handshake and receives a pipelined response with a configurable read latency. The block adds byte-enable writes, conflict arbitration, and error responses for misaligned or out-of-range addresses, which the plain instruction memory lacks.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/sram_be.sv | 37 +++
 rtl/tcm_mem.sv | 179 +++++++++++++++++
 tb/tb_tcm_mem.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the tightly-coupled memory.
package mem_pkg;

    localparam int unsigned MaxDataWidth = 64;
    localparam int unsigned MaxAddrWidth = 64;

    // Channel that owns a response.
    typedef enum logic {
        CH_IF = 1'b0,
        CH_LS = 1'b1
    } ch_e;

    // One response-pipeline stage. Data is sized for the widest configuration;
    // narrower instances zero-extend into it.
    typedef struct packed {
        logic                    valid;
        ch_e                     ch;
        logic                    err;
        logic [MaxDataWidth-1:0] data;
    } rsp_t;

    // Flags an access that is misaligned or lies above the word-index field.
    function automatic logic addr_err(input logic [MaxAddrWidth-1:0] addr,
                                      input int unsigned             off_bits,
                                      input int unsigned             idx_bits);
        logic [MaxAddrWidth-1:0] off_mask;
        logic                    misaligned;
        logic                    out_of_range;
        off_mask     = (MaxAddrWidth'(1) << off_bits) - MaxAddrWidth'(1);
        misaligned   = |(addr & off_mask);
        out_of_range = |(addr >> (off_bits + idx_bits));
        return misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/sram_be.sv
// Single-port word array with byte-enable writes and a registered read port.
// Contents are intentionally not reset.
module sram_be #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SRAM_DEPTH = 32'h0000_4000
) (
    input  logic                          clk_i,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [DATA_WIDTH/8-1:0]       be_i,
    input  logic [$clog2(SRAM_DEPTH)-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    output logic [DATA_WIDTH-1:0]         rdata_o
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [SRAM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-masked write and registered read on every enabled access.
    always_ff @(posedge clk_i) begin
        if (req_i) begin
            if (we_i) begin
                for (int n = 0; n < NumBytes; n++) begin
                    if (be_i[n]) begin
                        mem_q[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
                    end
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tcm_mem.sv
// Dual-channel TCM: fetch and load/store channels share one single-ported
// array through an alternating-priority arbiter and a fixed-latency
// response pipeline.
module tcm_mem
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SRAM_DEPTH = 32'h0000_4000,
    parameter int unsigned RD_LATENCY = 1,
    parameter bit          DATA_PRIO  = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    output logic                    if_err_o,
    input  logic                    ls_req_i,
    input  logic                    ls_we_i,
    input  logic [DATA_WIDTH/8-1:0] ls_be_i,
    input  logic [ADDR_WIDTH-1:0]   ls_addr_i,
    input  logic [DATA_WIDTH-1:0]   ls_wdata_i,
    output logic                    ls_gnt_o,
    output logic                    ls_rvalid_o,
    output logic [DATA_WIDTH-1:0]   ls_rdata_o,
    output logic                    ls_err_o
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned OffBits  = $clog2(NumBytes);
    localparam int unsigned IdxBits  = $clog2(SRAM_DEPTH);

    // Arbiter state: 1 means the load/store channel wins the next conflict.
    logic prio_q, prio_d;
    logic if_gnt, ls_gnt;

    // Accepted access.
    logic                  acc;
    ch_e                   acc_ch;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_err;
    logic                  acc_we;
    logic                  ram_req;
    logic [IdxBits-1:0]    ram_idx;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // First response stage; its data comes straight from the array register.
    logic s0_valid_q;
    ch_e  s0_ch_q;
    logic s0_err_q;
    logic s0_rd_q;
    rsp_t s0_rsp;
    rsp_t rsp_out;
    logic unused_data;

    // Grant decode: single requester always wins, conflicts go to prio holder.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        prio_d = prio_q;
        if (!rst_i) begin
            if (if_req_i && ls_req_i) begin
                if (prio_q) begin
                    ls_gnt = 1'b1;
                end else begin
                    if_gnt = 1'b1;
                end
                // Loser of this conflict wins the next one.
                prio_d = ~prio_q;
            end else begin
                if_gnt = if_req_i;
                ls_gnt = ls_req_i;
            end
        end
    end

    assign if_gnt_o = if_gnt;
    assign ls_gnt_o = ls_gnt;

    // Priority flop, restored to the configured holder on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q <= DATA_PRIO;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Select the accepted access and decode its address.
    always_comb begin
        acc      = if_gnt | ls_gnt;
        acc_ch   = ls_gnt ? CH_LS : CH_IF;
        acc_addr = ls_gnt ? ls_addr_i : if_addr_i;
        acc_err  = addr_err(MaxAddrWidth'(acc_addr), OffBits, IdxBits);
        acc_we   = ls_gnt & ls_we_i;
        // Error accesses never touch the array.
        ram_req  = acc & ~acc_err;
        ram_idx  = acc_addr[OffBits +: IdxBits];
    end

    sram_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .SRAM_DEPTH (SRAM_DEPTH)
    ) u_sram (
        .clk_i   (clk_i),
        .req_i   (ram_req),
        .we_i    (acc_we),
        .be_i    (ls_be_i),
        .addr_i  (ram_idx),
        .wdata_i (ls_wdata_i),
        .rdata_o (ram_rdata)
    );

    // Capture response attributes alongside the array read on the accept edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s0_valid_q <= 1'b0;
            s0_ch_q    <= CH_IF;
            s0_err_q   <= 1'b0;
            s0_rd_q    <= 1'b0;
        end else begin
            s0_valid_q <= acc;
            s0_ch_q    <= acc_ch;
            s0_err_q   <= acc & acc_err;
            // Only good reads return data; writes and errors return zero.
            s0_rd_q    <= ram_req & ~acc_we;
        end
    end

    // Assemble the first stage; array data is masked unless it is a good read.
    always_comb begin
        s0_rsp       = '0;
        s0_rsp.valid = s0_valid_q;
        s0_rsp.ch    = s0_ch_q;
        s0_rsp.err   = s0_err_q;
        s0_rsp.data  = s0_rd_q ? MaxDataWidth'(ram_rdata) : '0;
    end

    generate
        if (RD_LATENCY > 1) begin : g_pipe
            rsp_t pipe_q [RD_LATENCY-1];

            // Delay line; reset drops anything still in flight.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < RD_LATENCY - 1; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= s0_rsp;
                    for (int i = 1; i < RD_LATENCY - 1; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign rsp_out = pipe_q[RD_LATENCY-2];
        end else begin : g_nopipe
            assign rsp_out = s0_rsp;
        end
    endgenerate

    // Upper data bits exist only for the widest configuration.
    assign unused_data = ^(rsp_out.data >> DATA_WIDTH);

    // Steer the final stage to the owning channel; idle outputs are zero.
    always_comb begin
        if_rvalid_o = rsp_out.valid && (rsp_out.ch == CH_IF);
        ls_rvalid_o = rsp_out.valid && (rsp_out.ch == CH_LS);
        if_err_o    = if_rvalid_o && rsp_out.err;
        ls_err_o    = ls_rvalid_o && rsp_out.err;
        if_rdata_o  = if_rvalid_o ? rsp_out.data[DATA_WIDTH-1:0] : '0;
        ls_rdata_o  = ls_rvalid_o ? rsp_out.data[DATA_WIDTH-1:0] : '0;
    end

endmodule

// File: tb/tb_tcm_mem.sv
// Directed bench: three instances (read latency 1, 2, 3) share one stimulus.
module tb_tcm_mem;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;

    logic        d1_if_gnt, d1_if_rvalid, d1_if_err, d1_ls_gnt, d1_ls_rvalid, d1_ls_err;
    logic [31:0] d1_if_rdata, d1_ls_rdata;
    logic        d2_if_gnt, d2_if_rvalid, d2_if_err, d2_ls_gnt, d2_ls_rvalid, d2_ls_err;
    logic [31:0] d2_if_rdata, d2_ls_rdata;
    logic        d3_if_gnt, d3_if_rvalid, d3_if_err, d3_ls_gnt, d3_ls_rvalid, d3_ls_err;
    logic [31:0] d3_if_rdata, d3_ls_rdata;

    int checks = 0;
    int errors = 0;

    tcm_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SRAM_DEPTH(256), .RD_LATENCY(1),
              .DATA_PRIO(1'b1)) u_d1 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(d1_if_gnt),
        .if_rvalid_o(d1_if_rvalid), .if_rdata_o(d1_if_rdata), .if_err_o(d1_if_err),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_be_i(ls_be), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata), .ls_gnt_o(d1_ls_gnt), .ls_rvalid_o(d1_ls_rvalid),
        .ls_rdata_o(d1_ls_rdata), .ls_err_o(d1_ls_err)
    );

    tcm_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SRAM_DEPTH(256), .RD_LATENCY(2),
              .DATA_PRIO(1'b1)) u_d2 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(d2_if_gnt),
        .if_rvalid_o(d2_if_rvalid), .if_rdata_o(d2_if_rdata), .if_err_o(d2_if_err),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_be_i(ls_be), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata), .ls_gnt_o(d2_ls_gnt), .ls_rvalid_o(d2_ls_rvalid),
        .ls_rdata_o(d2_ls_rdata), .ls_err_o(d2_ls_err)
    );

    tcm_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SRAM_DEPTH(256), .RD_LATENCY(3),
              .DATA_PRIO(1'b1)) u_d3 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(d3_if_gnt),
        .if_rvalid_o(d3_if_rvalid), .if_rdata_o(d3_if_rdata), .if_err_o(d3_if_err),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_be_i(ls_be), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata), .ls_gnt_o(d3_ls_gnt), .ls_rvalid_o(d3_ls_rvalid),
        .ls_rdata_o(d3_ls_rdata), .ls_err_o(d3_ls_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 1'b0;
        ls_req = 1'b0;
        ls_we  = 1'b0;
        ls_be  = 4'h0;
    endtask

    task automatic ls_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            input logic exp_err);
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = a; ls_wdata = d; ls_be = be;
        #1;
        chk("wr_gnt", 32'(d1_ls_gnt), 32'd1);
        step();
        idle();
        chk("wr_rvalid", 32'(d1_ls_rvalid), 32'd1);
        chk("wr_rdata", d1_ls_rdata, 32'h0);
        chk("wr_err", 32'(d1_ls_err), 32'(exp_err));
    endtask

    task automatic ls_read(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_err);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = a; ls_be = 4'h0;
        #1;
        chk("rd_gnt", 32'(d1_ls_gnt), 32'd1);
        step();
        idle();
        chk("rd_rvalid", 32'(d1_ls_rvalid), 32'd1);
        chk("rd_rdata", d1_ls_rdata, exp_d);
        chk("rd_err", 32'(d1_ls_err), 32'(exp_err));
    endtask

    initial begin
        logic exp_ls;
        rst = 1'b1;
        idle();
        if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0;

        // Reset: grants blocked even with both requests high, outputs quiet.
        if_req = 1'b1; ls_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_gnt", 32'(d1_if_gnt), 32'd0);
        chk("rst_ls_gnt", 32'(d1_ls_gnt), 32'd0);
        chk("rst_if_rvalid", 32'(d1_if_rvalid), 32'd0);
        chk("rst_ls_rvalid", 32'(d3_ls_rvalid), 32'd0);
        chk("rst_if_rdata", d1_if_rdata, 32'h0);
        chk("rst_ls_err", 32'(d2_ls_err), 32'd0);
        rst = 1'b0;
        idle();

        // Preload through the load/store channel; first accept right after reset.
        ls_write(32'h0,  32'h0102_0304, 4'hF, 1'b0);
        ls_write(32'h4,  32'h0506_0708, 4'hF, 1'b0);
        ls_write(32'h8,  32'h090A_0B0C, 4'hF, 1'b0);
        ls_write(32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0);
        repeat (3) step();

        // Fetch-only read.
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        chk("f_if_gnt", 32'(d1_if_gnt), 32'd1);
        chk("f_ls_gnt", 32'(d1_ls_gnt), 32'd0);
        step();
        idle();
        chk("f_rvalid", 32'(d1_if_rvalid), 32'd1);
        chk("f_rdata", d1_if_rdata, 32'hDEAD_BEEF);
        chk("f_err", 32'(d1_if_err), 32'd0);
        chk("f_ls_quiet", 32'(d1_ls_rvalid), 32'd0);
        chk("f_l2_early", 32'(d2_if_rvalid), 32'd0);
        step();
        chk("f_rvalid_1cyc", 32'(d1_if_rvalid), 32'd0);
        chk("f_l2_rvalid", 32'(d2_if_rvalid), 32'd1);
        chk("f_l2_rdata", d2_if_rdata, 32'hDEAD_BEEF);

        // Byte enables, read-after-write next cycle, all-zero enables.
        ls_write(32'h80, 32'h1122_3344, 4'hF, 1'b0);
        ls_write(32'h80, 32'hAABB_CCDD, 4'h5, 1'b0);
        ls_read(32'h80, 32'h11BB_33DD, 1'b0);
        ls_write(32'h80, 32'hFFFF_FFFF, 4'h0, 1'b0);
        ls_read(32'h80, 32'h11BB_33DD, 1'b0);

        // Error accesses: misaligned load, out-of-range store, fetch beyond array.
        ls_read(32'h42, 32'h0, 1'b1);
        ls_write(32'h400, 32'hFFFF_FFFF, 4'hF, 1'b1);
        ls_read(32'h0, 32'h0102_0304, 1'b0);
        if_req = 1'b1; if_addr = 32'h1000_0000;
        #1;
        chk("fe_gnt", 32'(d1_if_gnt), 32'd1);
        step();
        idle();
        chk("fe_rvalid", 32'(d1_if_rvalid), 32'd1);
        chk("fe_err", 32'(d1_if_err), 32'd1);
        chk("fe_rdata", d1_if_rdata, 32'h0);
        repeat (3) step();

        // Conflict alternation: ls, if, ls, if.
        if_req = 1'b1; if_addr = 32'h40;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80;
        for (int i = 0; i < 4; i++) begin
            exp_ls = (i % 2 == 0);
            #1;
            chk("c_ls_gnt", 32'(d1_ls_gnt), 32'(exp_ls));
            chk("c_if_gnt", 32'(d1_if_gnt), 32'(!exp_ls));
            step();
            chk("c_ls_rvalid", 32'(d1_ls_rvalid), 32'(exp_ls));
            chk("c_if_rvalid", 32'(d1_if_rvalid), 32'(!exp_ls));
            chk("c_ls_rdata", d1_ls_rdata, exp_ls ? 32'h11BB_33DD : 32'h0);
            chk("c_if_rdata", d1_if_rdata, exp_ls ? 32'h0 : 32'hDEAD_BEEF);
            if (i >= 2) begin
                chk("c_l3_ls_rvalid", 32'(d3_ls_rvalid), 32'(i % 2 == 0));
                chk("c_l3_if_rvalid", 32'(d3_if_rvalid), 32'(i % 2 == 1));
            end
        end
        idle();
        step();
        chk("c_l3_tail_ls", 32'(d3_ls_rvalid), 32'd1);
        chk("c_l3_tail_ls_d", d3_ls_rdata, 32'h11BB_33DD);
        step();
        chk("c_l3_tail_if", 32'(d3_if_rvalid), 32'd1);
        chk("c_l3_tail_if_d", d3_if_rdata, 32'hDEAD_BEEF);
        step();
        chk("c_l3_done", 32'(d3_if_rvalid | d3_ls_rvalid), 32'd0);

        // Priority moves only on conflicts.
        if_req = 1'b1; ls_req = 1'b1;
        #1;
        chk("p_conflict_ls", 32'(d1_ls_gnt), 32'd1);
        step();
        if_req = 1'b0;
        #1;
        chk("p_single_ls", 32'(d1_ls_gnt), 32'd1);
        step();
        if_req = 1'b1;
        #1;
        chk("p_held_if", 32'(d1_if_gnt), 32'd1);
        chk("p_held_ls", 32'(d1_ls_gnt), 32'd0);
        step();
        idle();
        repeat (4) step();

        // Back-to-back fetches with latency 3.
        if_req = 1'b1; if_addr = 32'h0;
        #1;
        chk("b_gnt0", 32'(d1_if_gnt), 32'd1);
        step();
        chk("b_t1", 32'(d3_if_rvalid), 32'd0);
        if_addr = 32'h4;
        #1;
        chk("b_gnt1", 32'(d1_if_gnt), 32'd1);
        step();
        chk("b_t2", 32'(d3_if_rvalid), 32'd0);
        if_addr = 32'h8;
        step();
        idle();
        chk("b_t3_v", 32'(d3_if_rvalid), 32'd1);
        chk("b_t3_d", d3_if_rdata, 32'h0102_0304);
        step();
        chk("b_t4_v", 32'(d3_if_rvalid), 32'd1);
        chk("b_t4_d", d3_if_rdata, 32'h0506_0708);
        step();
        chk("b_t5_v", 32'(d3_if_rvalid), 32'd1);
        chk("b_t5_d", d3_if_rdata, 32'h090A_0B0C);
        step();
        chk("b_t6_v", 32'(d3_if_rvalid), 32'd0);
        repeat (2) step();

        // Reset mid-flight: conflict moves prio to fetch, then reset restores it.
        if_req = 1'b1; if_addr = 32'h40;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80;
        #1;
        chk("r_gnt", 32'(d1_ls_gnt), 32'd1);
        step();
        rst = 1'b1;
        #1;
        chk("r_l1_dropped", 32'(d1_ls_rvalid), 32'd0);
        chk("r_l1_rdata", d1_ls_rdata, 32'h0);
        chk("r_gnt_blocked", 32'(d1_ls_gnt | d1_if_gnt), 32'd0);
        step();
        chk("r_l2_dropped", 32'(d2_ls_rvalid), 32'd0);
        chk("r_l2_rdata", d2_ls_rdata, 32'h0);
        step();
        chk("r_l3_dropped", 32'(d3_ls_rvalid), 32'd0);
        rst = 1'b0;
        #1;
        chk("r_prio_ls", 32'(d1_ls_gnt), 32'd1);
        chk("r_prio_if", 32'(d1_if_gnt), 32'd0);
        step();
        idle();
        chk("r_after_rvalid", 32'(d1_ls_rvalid), 32'd1);
        chk("r_after_rdata", d1_ls_rdata, 32'h11BB_33DD);
        chk("r_l2_quiet", 32'(d2_ls_rvalid | d2_if_rvalid), 32'd0);
        step();
        chk("r_l2_new", 32'(d2_ls_rvalid), 32'd1);
        chk("r_l3_quiet", 32'(d3_ls_rvalid | d3_if_rvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
